// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
//
// Control unit of a multicycle ARM-style datapath. It sequences each
// instruction through FETCH / DECODE / EXECUTE / MEMORY / WRITEBACK states,
// decodes the 3-bit ALU operation, keeps the architectural NZCV register and
// gates every architectural write with the instruction's condition code.
//
// Parameters
//   MEM_WAIT    extra wait cycles in FETCH and MEMREAD (0..15)
//
// Configuration macro
//   ILLEGAL_TRAP_EN  when defined, Op=11 or Cond=1111 in DECODE parks the
//                    unit in HALT (Illegal=1, no writes) until rst_n.
//                    When undefined, Op=11 is a NOP and Cond=1111 is false.
//
// Ports
//   clk, rst_n           clock (rising edge), async active-low reset
//   Cond, Op, Funct, Rd  latched instruction fields
//   ALUFlags             {N,Z,C,V} from the ALU in the current cycle
//   PCWrite, MemWrite,
//   RegWrite, IRWrite    write enables (forced low while rst_n is low)
//   AdrSrc, ALUSrcA,
//   ALUSrcB, ResultSrc   datapath multiplexer selects
//   ImmSrc, RegSrc       immediate / register-address selects from Op
//   ALUControl           000 ADD, 001 SUB, 010 AND, 011 ORR, 101 MOV
//   Illegal              (ILLEGAL_TRAP_EN only) sticky trap indicator
//   Flags                registered {N,Z,C,V}
// ---------------------------------------------------------------------------
module multicycle_ctrl #(
    parameter int MEM_WAIT = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] ALUFlags,
    output logic       PCWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [2:0] ALUControl,
`ifdef ILLEGAL_TRAP_EN
    output logic       Illegal,
`endif
    output logic [3:0] Flags
);

    localparam int WCW = (MEM_WAIT < 1) ? 1 : $clog2(MEM_WAIT + 1);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_WAIT);

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_BRANCH
`ifdef ILLEGAL_TRAP_EN
        , S_HALT
`endif
    } state_t;

    state_t         state_q;
    state_t         state_next;
    logic [WCW-1:0] wait_cnt;
    logic           wait_last;
    logic           cond_ex_q;
    logic           cond_ex;

    logic [3:0]     cmd;
    logic           s_bit;
    logic           is_cmp;
    logic           arith_cmd;
    logic [2:0]     alu_dec;
    logic           is_exec;
    logic           flag_we_nz;
    logic           flag_we_cv;

    logic           pc_write_s;
    logic           mem_write_s;
    logic           reg_write_s;
    logic           ir_write_s;

    // Condition-code evaluation against the architectural flags.
    function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'b0000: cond_holds = z;
            4'b0001: cond_holds = ~z;
            4'b0010: cond_holds = cy;
            4'b0011: cond_holds = ~cy;
            4'b0100: cond_holds = n;
            4'b0101: cond_holds = ~n;
            4'b0110: cond_holds = v;
            4'b0111: cond_holds = ~v;
            4'b1000: cond_holds = cy & ~z;
            4'b1001: cond_holds = ~cy | z;
            4'b1010: cond_holds = (n == v);
            4'b1011: cond_holds = (n != v);
            4'b1100: cond_holds = ~z & (n == v);
            4'b1101: cond_holds = z | (n != v);
            4'b1110: cond_holds = 1'b1;
            default: cond_holds = 1'b0;   // 1111: never
        endcase
    endfunction

    assign cmd       = Funct[4:1];
    assign s_bit     = Funct[0];
    assign is_cmp    = (cmd == CMD_CMP);
    assign arith_cmd = (cmd == CMD_ADD) || (cmd == CMD_SUB) || is_cmp;
    // Registered flags only: the ALU flags of this cycle belong to a
    // different operation than the one whose condition is being decided.
    assign cond_ex   = cond_holds(Cond, Flags);
    assign wait_last = (wait_cnt == WAIT_LAST);

    always_comb begin
        case (cmd)
            CMD_ADD: alu_dec = 3'b000;
            CMD_SUB: alu_dec = 3'b001;
            CMD_AND: alu_dec = 3'b010;
            CMD_ORR: alu_dec = 3'b011;
            CMD_MOV: alu_dec = 3'b101;
            CMD_CMP: alu_dec = 3'b001;
            default: alu_dec = 3'b000;
        endcase
    end

    assign is_exec    = (state_q == S_EXECUTER) || (state_q == S_EXECUTEI);
    assign flag_we_nz = is_exec && cond_ex_q && (s_bit || is_cmp);
    assign flag_we_cv = flag_we_nz && arith_cmd;

    // Decoded straight from the instruction, independent of state.
    assign ImmSrc = Op;
    assign RegSrc = {Op == 2'b01, Op == 2'b10};

    // Next-state and Moore outputs.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // a variable unassigned, which would otherwise infer a latch.
        state_next  = state_q;
        pc_write_s  = 1'b0;
        mem_write_s = 1'b0;
        reg_write_s = 1'b0;
        ir_write_s  = 1'b0;
        AdrSrc      = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ResultSrc   = 2'b00;
        ALUControl  = 3'b000;

        case (state_q)
            S_FETCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                if (wait_last) begin
                    ir_write_s = 1'b1;
                    pc_write_s = 1'b1;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
`ifdef ILLEGAL_TRAP_EN
                if (Op == 2'b11 || Cond == 4'b1111) begin
                    state_next = S_HALT;
                end else
`endif
                begin
                    case (Op)
                        2'b01:   state_next = S_MEMADR;
                        2'b00:   state_next = Funct[5] ? S_EXECUTEI : S_EXECUTER;
                        2'b10:   state_next = S_BRANCH;
                        default: state_next = S_FETCH;
                    endcase
                end
            end
            S_MEMADR: begin
                ALUSrcB    = 2'b01;
                state_next = s_bit ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                if (wait_last) state_next = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc   = 2'b01;
                reg_write_s = cond_ex_q;
                state_next  = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc      = 1'b1;
                mem_write_s = cond_ex_q;
                state_next  = S_FETCH;
            end
            S_EXECUTER: begin
                ALUSrcB    = 2'b00;
                ALUControl = alu_dec;
                state_next = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcB    = 2'b01;
                ALUControl = alu_dec;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                ResultSrc   = 2'b00;
                reg_write_s = cond_ex_q & ~is_cmp;
                pc_write_s  = cond_ex_q & ~is_cmp & (Rd == 4'b1111);
                state_next  = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcB    = 2'b01;
                ResultSrc  = 2'b10;
                pc_write_s = cond_ex_q;
                state_next = S_FETCH;
            end
`ifdef ILLEGAL_TRAP_EN
            S_HALT: state_next = S_HALT;   // only rst_n leaves HALT
`endif
            default: state_next = S_FETCH;
        endcase
    end

    // Write enables drop the moment reset asserts, not at the next edge.
    assign PCWrite  = pc_write_s  & rst_n;
    assign MemWrite = mem_write_s & rst_n;
    assign RegWrite = reg_write_s & rst_n;
    assign IRWrite  = ir_write_s  & rst_n;

`ifdef ILLEGAL_TRAP_EN
    assign Illegal = (state_q == S_HALT);
`endif

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            Flags     <= 4'b0000;
            cond_ex_q <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            state_q <= state_next;

            if (state_q == S_DECODE) cond_ex_q <= cond_ex;

            if ((state_q == S_FETCH || state_q == S_MEMREAD) && !wait_last)
                wait_cnt <= wait_cnt + 1'b1;
            else
                wait_cnt <= '0;

            if (flag_we_nz) Flags[3:2] <= ALUFlags[3:2];
            if (flag_we_cv) Flags[1:0] <= ALUFlags[1:0];
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl
//
// Two DUT lanes (MEM_WAIT=0 and MEM_WAIT=2) run side by side. Each lane's
// driver walks instructions through an instruction-level reference model that
// emits the expected output vector for every cycle into a scoreboard queue;
// a monitor pops and compares one entry per cycle on the falling edge.
// Compile with +define+ILLEGAL_TRAP_EN to exercise the trap build.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;

    typedef struct packed {
        logic       pc_write;
        logic       mem_write;
        logic       reg_write;
        logic       ir_write;
        logic       adr_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic [1:0] imm_src;
        logic [1:0] reg_src;
        logic [2:0] alu_control;
        logic [3:0] flags;
        logic       illegal;
    } out_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit lane_done [2];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic cond_ref(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c)
            0: return z;            1: return !z;
            2: return cy;           3: return !cy;
            4: return n;            5: return !n;
            6: return v;            7: return !v;
            8: return cy && !z;     9: return !cy || z;
            10: return n == v;      11: return n != v;
            12: return !z && n == v;
            13: return z || n != v;
            14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] alu_ref(input logic [3:0] c);
        case (c)
            4'b0100: return 3'd0;
            4'b0010: return 3'd1;
            4'b0000: return 3'd2;
            4'b1100: return 3'd3;
            4'b1101: return 3'd5;
            4'b1010: return 3'd1;
            default: return 3'd0;
        endcase
    endfunction

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int MW = (g == 0) ? 0 : 2;

        logic       rst_n = 1'b0;
        logic [3:0] cond = '0, rd = '0, alu_flags = '0;
        logic [1:0] op = '0;
        logic [5:0] funct = '0;
        logic       pc_write, mem_write, reg_write, ir_write, adr_src, alu_src_a;
        logic [1:0] alu_src_b, result_src, imm_src, reg_src;
        logic [2:0] alu_control;
        logic [3:0] flags;
        logic       illegal;
        out_t       act;

        out_t       q  [$];
        string      tq [$];
        logic [3:0] mflags = '0;
        bit         active = 1'b0;
        int         n_instr = 0;

        multicycle_ctrl #(.MEM_WAIT(MW)) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .Cond      (cond),
            .Op        (op),
            .Funct     (funct),
            .Rd        (rd),
            .ALUFlags  (alu_flags),
            .PCWrite   (pc_write),
            .MemWrite  (mem_write),
            .RegWrite  (reg_write),
            .IRWrite   (ir_write),
            .AdrSrc    (adr_src),
            .ALUSrcA   (alu_src_a),
            .ALUSrcB   (alu_src_b),
            .ResultSrc (result_src),
            .ImmSrc    (imm_src),
            .RegSrc    (reg_src),
            .ALUControl(alu_control),
`ifdef ILLEGAL_TRAP_EN
            .Illegal   (illegal),
`endif
            .Flags     (flags)
        );
`ifndef ILLEGAL_TRAP_EN
        assign illegal = 1'b0;
`endif

        assign act = out_t'({pc_write, mem_write, reg_write, ir_write, adr_src, alu_src_a,
                             alu_src_b, result_src, imm_src, reg_src, alu_control, flags,
                             illegal});

        // Monitor: one expected vector per cycle while the lane is active.
        initial forever begin
            @(negedge clk);
            if (active) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL lane%0d scoreboard: got empty queue expected an entry", g);
                end else begin
                    out_t  e;
                    string t;
                    e = q.pop_front();
                    t = tq.pop_front();
                    check(t, 32'(act), 32'(e));
                end
            end
        end

        function automatic out_t base();
            out_t e;
            e         = '0;
            e.imm_src = op;
            e.reg_src = {op == 2'b01, op == 2'b10};
            e.flags   = mflags;
            return e;
        endfunction

        task automatic cyc(input out_t e, input logic [3:0] af, input string tag);
            alu_flags = af;
            q.push_back(e);
            tq.push_back(tag);
            @(posedge clk);
            #1;
        endtask

        // Holds reset for one cycle, checking the forced-low enables and the
        // cleared flags, then releases just after a rising edge.
        task automatic reset_pulse(input string tag);
            active = 1'b0;
            rst_n  = 1'b0;
            #1;
            check({tag, " write enables"}, 32'({pc_write, mem_write, reg_write, ir_write}), 32'd0);
            check({tag, " Flags"}, 32'(flags), 32'd0);
            @(posedge clk);
            #1;
            rst_n  = 1'b1;
            mflags = 4'b0000;
            active = 1'b1;
        endtask

        task automatic instr(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                             input logic [3:0] r, input logic [3:0] af, input bit rst_mid);
            out_t       e;
            logic       ce;
            logic [3:0] cmd;
            logic       is_cmp;
            string      t;
            cond = c; op = o; funct = f; rd = r;
            n_instr++;
            t      = $sformatf("lane%0d instr%0d", g, n_instr);
            cmd    = f[4:1];
            is_cmp = (cmd == 4'b1010);

            for (int w = 0; w <= MW; w++) begin
                e = base();
                e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.result_src = 2'b10;
                if (w == MW) begin e.ir_write = 1'b1; e.pc_write = 1'b1; end
                cyc(e, 4'($urandom), {t, " FETCH"});
            end

            ce = cond_ref(c, mflags);
            e = base();
            e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.result_src = 2'b10;
            cyc(e, 4'($urandom), {t, " DECODE"});

`ifdef ILLEGAL_TRAP_EN
            if (o == 2'b11 || c == 4'b1111) begin
                for (int k = 0; k < 10; k++) begin
                    e = base();
                    e.illegal = 1'b1;
                    cyc(e, 4'($urandom), {t, " HALT"});
                end
                reset_pulse({t, " halt reset"});
                return;
            end
`endif

            case (o)
                2'b01: begin
                    e = base(); e.alu_src_b = 2'b01;
                    cyc(e, 4'($urandom), {t, " MEMADR"});
                    if (f[0]) begin
                        for (int w = 0; w <= MW; w++) begin
                            e = base(); e.adr_src = 1'b1;
                            cyc(e, 4'($urandom), {t, " MEMREAD"});
                        end
                        e = base(); e.result_src = 2'b01; e.reg_write = ce;
                        cyc(e, 4'($urandom), {t, " MEMWB"});
                    end else begin
                        e = base(); e.adr_src = 1'b1; e.mem_write = ce;
                        if (rst_mid) begin
                            alu_flags = 4'($urandom);
                            q.push_back(e);
                            tq.push_back({t, " MEMWRITE"});
                            @(negedge clk);
                            #2;
                            check({t, " MemWrite before reset"}, 32'(mem_write), 32'(ce));
                            reset_pulse({t, " mid-MEMWRITE reset"});
                        end else begin
                            cyc(e, 4'($urandom), {t, " MEMWRITE"});
                        end
                    end
                end
                2'b00: begin
                    e = base();
                    e.alu_src_b   = f[5] ? 2'b01 : 2'b00;
                    e.alu_control = alu_ref(cmd);
                    cyc(e, af, {t, " EXECUTE"});
                    if (ce && (f[0] || is_cmp)) begin
                        mflags[3:2] = af[3:2];
                        if (cmd == 4'b0100 || cmd == 4'b0010 || is_cmp) mflags[1:0] = af[1:0];
                    end
                    e = base();
                    e.reg_write = ce && !is_cmp;
                    e.pc_write  = ce && !is_cmp && (r == 4'hF);
                    cyc(e, 4'($urandom), {t, " ALUWB"});
                end
                2'b10: begin
                    e = base();
                    e.alu_src_b = 2'b01; e.result_src = 2'b10; e.pc_write = ce;
                    cyc(e, 4'($urandom), {t, " BRANCH"});
                end
                default: ;   // NOP: straight back to FETCH
            endcase
        endtask

        initial begin
            logic [3:0] cmds [6];
            cmds = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1101, 4'b1010};
            repeat (2) @(posedge clk);
            #1;
            reset_pulse($sformatf("lane%0d power-on reset", g));

            instr(4'hE, 2'b00, 6'b001001, 4'd2, 4'b0110, 1'b0);  // ADDS reg -> 0110
            instr(4'hE, 2'b00, 6'b010101, 4'd0, 4'b0100, 1'b0);  // CMP -> 0100
            instr(4'h1, 2'b00, 6'b000101, 4'd3, 4'b1011, 1'b0);  // SUBS NE: skipped
            instr(4'hE, 2'b01, 6'b011001, 4'd4, 4'b0000, 1'b0);  // LDR
            instr(4'h0, 2'b10, 6'b000000, 4'd0, 4'b0000, 1'b0);  // BEQ taken (Z=1)
            instr(4'hE, 2'b00, 6'b101001, 4'd5, 4'b0000, 1'b0);  // ADDS imm -> 0000
            instr(4'h0, 2'b10, 6'b000000, 4'd0, 4'b0000, 1'b0);  // BEQ not taken
            instr(4'hE, 2'b00, 6'b001000, 4'hF, 4'b1111, 1'b0);  // ADD to PC
            instr(4'hE, 2'b00, 6'b111011, 4'd6, 4'b1010, 1'b0);  // MOVS imm: NZ only
            instr(4'hE, 2'b00, 6'b001001, 4'd7, 4'b1010, 1'b0);  // ADDS -> 1010
            instr(4'hE, 2'b01, 6'b011000, 4'd1, 4'b0000, 1'b1);  // STR, reset mid-write
            instr(4'hE, 2'b11, 6'b000000, 4'd0, 4'b0000, 1'b0);  // Op=11
            instr(4'hF, 2'b00, 6'b001001, 4'd2, 4'b1111, 1'b0);  // Cond=1111

            for (int i = 0; i < 120; i++) begin
                logic [3:0] c, r;
                logic [5:0] f;
                c = ($urandom_range(0, 19) == 0) ? 4'hF : 4'($urandom_range(0, 14));
                f = 6'($urandom);
                if ($urandom_range(0, 3) != 0) f[4:1] = cmds[$urandom_range(0, 5)];
                r = ($urandom_range(0, 5) == 0) ? 4'hF : 4'($urandom);
                instr(c, 2'($urandom), f, r, 4'($urandom), 1'b0);
            end

            active = 1'b0;
            lane_done[g] = 1'b1;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected both lanes finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        wait (lane_done[0] && lane_done[1]);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multicycle control unit sitting directly upstream of the datapath ALU.
- Decodes the latched instruction fields and sequences the datapath through fetch/decode/execute/memory/writeback states.
- Drives the 3-bit ALUControl encoding the ALU consumes.
- Consumes the ALU's NZCV flags into an architectural flag register and applies condition-code gating to every architectural write.

Parameters:
- MEM_WAIT, 0, extra wait cycles inserted in FETCH and MEMREAD before the memory access completes (0..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- Cond  input  4  instruction condition field [31:28].
- Op  input  2  instruction op field [27:26].
- Funct  input  6  instruction funct field [25:20]; [5]=I, [4:1]=cmd, [0]=S or L.
- Rd  input  4  destination register [15:12].
- ALUFlags  input  4  {N,Z,C,V} from the ALU, same cycle.
- PCWrite  output  1  PC register enable.
- MemWrite  output  1  data memory write enable.
- RegWrite  output  1  register file write enable.
- IRWrite  output  1  instruction register enable.
- AdrSrc  output  1  0=PC, 1=ALUOut as memory address.
- ALUSrcA  output  1  0=RD1, 1=PC.
- ALUSrcB  output  2  00=RD2, 01=ExtImm, 10=constant 4.
- ResultSrc  output  2  00=ALUOut, 01=ReadData, 10=ALU result direct.
- ImmSrc  output  2  equals Op.
- RegSrc  output  2  [0]=(Op==10), [1]=(Op==01).
- ALUControl  output  3  000 ADD, 001 SUB, 010 AND, 011 ORR, 101 MOV.
- Flags  output  4  registered {N,Z,C,V}.

Behaviour:
- Reset (async, rst_n low): state=FETCH, Flags=0000, cond_ex_q=0, wait_cnt=0. While rst_n is low, PCWrite, MemWrite, RegWrite and IRWrite are forced to 0 combinationally.
- Moore outputs are decoded from the state register. Unlisted outputs in a state are 0 (ALUControl=000).
- FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - Stays MEM_WAIT extra cycles, counting wait_cnt 0..MEM_WAIT.
  - IRWrite=1 and PCWrite=1 (unconditional) only on the final cycle, then -> DECODE.
- DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - cond_ex_q <= CondEx(Cond, Flags).
  - Next state by Op: 01 -> MEMADR; 00 with Funct[5]=0 -> EXECUTER; 00 with Funct[5]=1 -> EXECUTEI; 10 -> BRANCH; 11 -> FETCH (NOP).
- MEMADR: ALUSrcB=01. Funct[0]=1 -> MEMREAD, else -> MEMWRITE.
- MEMREAD: AdrSrc=1. Waits MEM_WAIT extra cycles, then -> MEMWB.
- MEMWB: ResultSrc=01. RegWrite=cond_ex_q. -> FETCH.
- MEMWRITE: AdrSrc=1. MemWrite=cond_ex_q. -> FETCH.
- EXECUTER / EXECUTEI: ALUSrcB=00 / 01, ALUControl=decoded. Flag write per the rules below. -> ALUWB.
- ALUWB: ResultSrc=00.
  - RegWrite = cond_ex_q & ~NoWrite.
  - PCWrite = cond_ex_q & ~NoWrite & (Rd==1111).
  - -> FETCH.
- BRANCH: ALUSrcB=01, ResultSrc=10. PCWrite=cond_ex_q. -> FETCH.
- ALU decode by cmd: 0100 -> 000; 0010 -> 001; 0000 -> 010; 1100 -> 011; 1101 -> 101; 1010 (CMP) -> 001 with NoWrite=1. Any other cmd -> 000.
- Flag write, in EXECUTER/EXECUTEI only, on the clock edge, gated by cond_ex_q:
  - NZ <= ALUFlags[3:2] if S=1 or CMP.
  - CV <= ALUFlags[1:0] if (S=1 or CMP) and cmd is ADD/SUB/CMP.
- CondEx codes:
  - EQ Z, NE ~Z, CS C, CC ~C, MI N, PL ~N, VS V, VC ~V.
  - HI C&~Z, LS ~C|Z, GE N==V, LT N!=V, GT ~Z&(N==V), LE Z|(N!=V).
  - AL 1; 1111 -> 0.
- CondEx always uses the registered Flags, never the same-cycle ALUFlags.
- wait_cnt clears on leaving FETCH/MEMREAD. Width is max(1, clog2(MEM_WAIT+1)).

Optional Feature:
- Macro ILLEGAL_TRAP_EN.
- Defined:
  - DECODE with Op=11 or Cond=1111 -> HALT state.
  - Output Illegal (1 bit, sticky) =1 in HALT.
  - All write enables are 0 in HALT; leaving HALT requires rst_n.
- Undefined: no Illegal port. Op=11 returns to FETCH as a NOP; Cond=1111 simply evaluates false.

Test Plan:
- Reset, MEM_WAIT=0, Cond=1110 Op=00 Funct=001001 (ADDS reg), ALUFlags=0110 -> states FETCH, DECODE, EXECUTER, ALUWB, FETCH; ALUControl=000 in EXECUTER; Flags=0110 afterwards; RegWrite=1 only in ALUWB.
- CMP (Funct=010101) with ALUFlags=0100 -> Flags=0100, RegWrite=0 in ALUWB. Then SUB with Cond=0001 (NE) -> cond_ex_q=0, RegWrite=0, Flags stay 0100.
- MEM_WAIT=2, LDR (Op=01 Funct[0]=1) -> FETCH lasts 3 cycles with IRWrite/PCWrite only on the 3rd; MEMREAD lasts 3 cycles, AdrSrc=1; RegWrite=1 in MEMWB.
- BEQ (Op=10 Cond=0000) with Flags Z=1 -> PCWrite=1 in BRANCH. Repeat with Z=0 -> PCWrite=0 and next state FETCH.
- rst_n pulsed low mid-MEMWRITE -> MemWrite falls without waiting for a clock edge; state=FETCH and Flags=0000 after release.
- ILLEGAL_TRAP_EN defined, Op=11 -> HALT, Illegal=1, no write enables for 10 cycles; cleared only by rst_n.
